// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic light controller and its monitor:
// light encodings, error cause codes, monitor FSM states and sequencing helpers.
package traffic_light_pkg;

    localparam logic [1:0] ST_RED     = 2'b00;
    localparam logic [1:0] ST_GREEN   = 2'b01;
    localparam logic [1:0] ST_YELLOW  = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_DWELL   = 2'd1;
    localparam logic [1:0] ERR_SEQ     = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL = 2'd3;

    typedef enum logic {
        MON_UNLOCKED = 1'b0,
        MON_LOCKED   = 1'b1
    } mon_state_e;

    // ST_ILLEGAL maps to itself so it can never look like a legal successor.
    function automatic logic [1:0] next_state(input logic [1:0] s);
        case (s)
            ST_RED:    return ST_GREEN;
            ST_GREEN:  return ST_YELLOW;
            ST_YELLOW: return ST_RED;
            default:   return ST_ILLEGAL;
        endcase
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tl_dwell_counter.sv
// Saturating phase-dwell counter: loads 1 on a phase change, otherwise counts up
// and holds at all-ones.
module tl_dwell_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Lamp driver and sequence/dwell checker for the traffic light state bus.
// Define TRAFFIC_LIGHT_MONITOR_TIMEOUT_EN to build the per-phase watchdog.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int RED_CYC    = 4,
    parameter int GREEN_CYC  = 3,
    parameter int YELLOW_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       state,
    output logic             red_on,
    output logic             green_on,
    output logic             yellow_on,
    output logic             locked,
    output logic [CNT_W-1:0] dwell_cnt,
    output logic             err_illegal,
    output logic             err_seq,
    output logic             err_dwell,
    output logic             err_timeout,
    output logic             err_sticky,
    output logic [1:0]       err_code
);

`ifdef TRAFFIC_LIGHT_MONITOR_TIMEOUT_EN
    // Fire on the edge where the counter reaches the limit, i.e. while it reads limit-1.
    localparam logic [CNT_W-1:0] TIMEOUT_PRE =
        CNT_W'(2 * max3(RED_CYC, GREEN_CYC, YELLOW_CYC) - 1);
`endif

    logic [1:0]       state_q, state_d;
    logic             primed_q, primed_d;
    mon_state_e       mon_q, mon_d;
    logic [2:0]       lamp_q, lamp_d;
    logic             err_illegal_q, err_illegal_d;
    logic             err_seq_q, err_seq_d;
    logic             err_dwell_q, err_dwell_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_sticky_q, err_sticky_d;
    logic [1:0]       err_code_q, err_code_d;

    logic             is_illegal;
    logic             transition;
    logic             legal_succ;
    logic             is_locked;
    logic [CNT_W-1:0] dwell_q;
    logic [CNT_W-1:0] req_dwell;

    tl_dwell_counter #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .clear (transition),
        .cnt   (dwell_q)
    );

    // Lamp bit gi lights for code gi; red doubles as the fail-safe for 11.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lamp
            if (gi == 0) begin : g_red
                assign lamp_d[gi] = (state == ST_RED) || (state == ST_ILLEGAL);
            end else begin : g_other
                assign lamp_d[gi] = (state == 2'(gi));
            end
        end
    endgenerate

    always_comb begin
        state_d    = state;
        primed_d   = 1'b1;
        is_illegal = (state == ST_ILLEGAL);
        is_locked  = (mon_q == MON_LOCKED);
        // The first sample after reset is compared against a forced RED, not a
        // real previous phase, so it is never treated as a transition.
        transition = primed_q && (state != state_q);
        legal_succ = (state_q != ST_ILLEGAL) && (state == next_state(state_q));

        req_dwell = '0;
        case (state_q)
            ST_RED:    req_dwell = CNT_W'(RED_CYC);
            ST_GREEN:  req_dwell = CNT_W'(GREEN_CYC);
            ST_YELLOW: req_dwell = CNT_W'(YELLOW_CYC);
            default:   req_dwell = '0;
        endcase

        err_illegal_d = is_illegal;
        err_seq_d     = is_locked && transition && !is_illegal && !legal_succ;
        err_dwell_d   = is_locked && transition && legal_succ && (dwell_q != req_dwell);
`ifdef TRAFFIC_LIGHT_MONITOR_TIMEOUT_EN
        err_timeout_d = is_locked && !transition && (dwell_q == TIMEOUT_PRE);
`else
        err_timeout_d = 1'b0;
`endif

        mon_d = mon_q;
        case (mon_q)
            MON_UNLOCKED: if (transition && legal_succ) mon_d = MON_LOCKED;
            MON_LOCKED:   if (is_illegal || err_seq_d || err_timeout_d) mon_d = MON_UNLOCKED;
            default:      mon_d = MON_UNLOCKED;
        endcase

        err_sticky_d = err_sticky_q | err_illegal_d | err_seq_d | err_dwell_d | err_timeout_d;

        err_code_d = err_code_q;
        if (err_code_q == ERR_NONE) begin
            if (err_illegal_d || err_timeout_d) begin
                err_code_d = ERR_ILLEGAL;
            end else if (err_seq_d) begin
                err_code_d = ERR_SEQ;
            end else if (err_dwell_d) begin
                err_code_d = ERR_DWELL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RED;
            primed_q      <= 1'b0;
            mon_q         <= MON_UNLOCKED;
            lamp_q        <= 3'b001;
            err_illegal_q <= 1'b0;
            err_seq_q     <= 1'b0;
            err_dwell_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_sticky_q  <= 1'b0;
            err_code_q    <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            primed_q      <= primed_d;
            mon_q         <= mon_d;
            lamp_q        <= lamp_d;
            err_illegal_q <= err_illegal_d;
            err_seq_q     <= err_seq_d;
            err_dwell_q   <= err_dwell_d;
            err_timeout_q <= err_timeout_d;
            err_sticky_q  <= err_sticky_d;
            err_code_q    <= err_code_d;
        end
    end

    assign red_on      = lamp_q[0];
    assign green_on    = lamp_q[1];
    assign yellow_on   = lamp_q[2];
    assign locked      = (mon_q == MON_LOCKED);
    assign dwell_cnt   = dwell_q;
    assign err_illegal = err_illegal_q;
    assign err_seq     = err_seq_q;
    assign err_dwell   = err_dwell_q;
    assign err_timeout = err_timeout_q;
    assign err_sticky  = err_sticky_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with default parameters; honours
// TRAFFIC_LIGHT_MONITOR_TIMEOUT_EN for the watchdog expectations.
module tb_traffic_light_monitor;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] G = 2'b01;
    localparam logic [1:0] Y = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state;
    logic       red_on, green_on, yellow_on, locked;
    logic [7:0] dwell_cnt;
    logic       err_illegal, err_seq, err_dwell, err_timeout, err_sticky;
    logic [1:0] err_code;

    int n_cmp = 0;
    int n_mis = 0;

    traffic_light_monitor #(
        .RED_CYC    (4),
        .GREEN_CYC  (3),
        .YELLOW_CYC (2),
        .CNT_W      (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .state       (state),
        .red_on      (red_on),
        .green_on    (green_on),
        .yellow_on   (yellow_on),
        .locked      (locked),
        .dwell_cnt   (dwell_cnt),
        .err_illegal (err_illegal),
        .err_seq     (err_seq),
        .err_dwell   (err_dwell),
        .err_timeout (err_timeout),
        .err_sticky  (err_sticky),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // {yellow, green, red}
    function automatic logic [2:0] exp_lamps(input logic [1:0] s);
        case (s)
            2'b00:   return 3'b001;
            2'b01:   return 3'b010;
            2'b10:   return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

    // Drive one sample; outputs are looked at 1 time unit after the capturing edge.
    task automatic step(input logic [1:0] s);
        state = s;
        @(posedge clk);
        #1;
        $display("[%0t] rst=%0b state=%0d lamps(y,g,r)=%b%b%b dwell=%0d locked=%0b ill=%0b seq=%0b dwl=%0b to=%0b sticky=%0b code=%0d",
                 $time, rst, s, yellow_on, green_on, red_on, dwell_cnt, locked,
                 err_illegal, err_seq, err_dwell, err_timeout, err_sticky, err_code);
    endtask

    task automatic hold_clean(input logic [1:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            step(s);
            chk("lamps", {yellow_on, green_on, red_on}, exp_lamps(s));
            chk("no_err_pulse", {err_illegal, err_seq, err_dwell, err_timeout}, 4'b0000);
        end
    endtask

    task automatic pulse_reset(input logic [1:0] s);
        rst = 1'b1;
        step(s);
        rst = 1'b0;
        chk("rst_lamps", {yellow_on, green_on, red_on}, 3'b001);
        chk("rst_locked", locked, 1'b0);
        chk("rst_dwell", dwell_cnt, 8'd0);
        chk("rst_pulses", {err_illegal, err_seq, err_dwell, err_timeout}, 4'b0000);
        chk("rst_sticky", err_sticky, 1'b0);
        chk("rst_code", err_code, 2'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        state = R;
        step(R);
        pulse_reset(R);

        // Legal sequence from reset; first RED is partial.
        hold_clean(R, 3);
        chk("partial_unlocked", locked, 1'b0);
        chk("partial_dwell", dwell_cnt, 8'd3);
        hold_clean(G, 1);
        chk("lock_on_rg", locked, 1'b1);
        chk("dwell_cleared", dwell_cnt, 8'd1);
        hold_clean(G, 2);
        repeat (2) begin
            hold_clean(Y, 2);
            hold_clean(R, 4);
            hold_clean(G, 3);
        end
        hold_clean(Y, 2);
        hold_clean(R, 4);
        chk("legal_locked", locked, 1'b1);
        chk("legal_code", err_code, 2'd0);
        chk("legal_sticky", err_sticky, 1'b0);
        chk("legal_dwell_red", dwell_cnt, 8'd4);

        // Skip RED->YELLOW while locked.
        step(Y);
        chk("skip_seq", err_seq, 1'b1);
        chk("skip_no_dwell", err_dwell, 1'b0);
        chk("skip_unlock", locked, 1'b0);
        chk("skip_code", err_code, 2'd2);
        chk("skip_sticky", err_sticky, 1'b1);
        step(Y);
        chk("skip_seq_1cyc", err_seq, 1'b0);
        chk("skip_still_unlocked", locked, 1'b0);
        step(R);
        chk("relock", locked, 1'b1);
        chk("relock_no_dwell", err_dwell, 1'b0);
        chk("relock_no_seq", err_seq, 1'b0);
        hold_clean(R, 3);
        hold_clean(G, 1);

        // Reset mid-GREEN; remainder of GREEN is partial and unchecked.
        pulse_reset(G);
        hold_clean(G, 2);
        chk("post_rst_unlocked", locked, 1'b0);
        chk("post_rst_dwell", dwell_cnt, 8'd2);
        hold_clean(Y, 1);
        chk("post_rst_lock", locked, 1'b1);
        hold_clean(Y, 1);
        hold_clean(R, 4);

        // Short GREEN (2 instead of 3).
        hold_clean(G, 2);
        step(Y);
        chk("short_dwell", err_dwell, 1'b1);
        chk("short_no_seq", err_seq, 1'b0);
        chk("short_code", err_code, 2'd1);
        chk("short_sticky", err_sticky, 1'b1);
        chk("short_locked", locked, 1'b1);
        step(Y);
        chk("short_dwell_1cyc", err_dwell, 1'b0);

        // Code 11 for three cycles; first error (dwell) keeps err_code.
        for (int i = 0; i < 3; i++) begin
            step(X);
            chk("ill_pulse", err_illegal, 1'b1);
            chk("ill_lamps", {yellow_on, green_on, red_on}, 3'b001);
            chk("ill_unlocked", locked, 1'b0);
            chk("ill_code_kept", err_code, 2'd1);
        end
        step(R);
        chk("ill_clear", err_illegal, 1'b0);
        chk("ret_unlocked", locked, 1'b0);
        chk("ret_dwell", dwell_cnt, 8'd1);
        hold_clean(R, 1);
        hold_clean(G, 1);
        chk("ret_relock", locked, 1'b1);

        // Long GREEN: watchdog at dwell 8 when enabled.
        pulse_reset(R);
        hold_clean(R, 4);
        hold_clean(G, 1);
        chk("to_locked", locked, 1'b1);
        hold_clean(G, 6);
        chk("to_dwell7", dwell_cnt, 8'd7);
        step(G);
        chk("to_dwell8", dwell_cnt, 8'd8);
`ifdef TRAFFIC_LIGHT_MONITOR_TIMEOUT_EN
        chk("to_pulse", err_timeout, 1'b1);
        chk("to_code", err_code, 2'd3);
        chk("to_unlock", locked, 1'b0);
        chk("to_sticky", err_sticky, 1'b1);
`else
        chk("to_off", err_timeout, 1'b0);
        chk("to_off_code", err_code, 2'd0);
        chk("to_off_locked", locked, 1'b1);
`endif
        step(G);
        chk("to_once", err_timeout, 1'b0);
        chk("to_dwell9", dwell_cnt, 8'd9);

        // Saturation of the dwell counter.
        repeat (246) step(G);
        chk("sat_reach", dwell_cnt, 8'd255);
        chk("sat_no_timeout", err_timeout, 1'b0);
        step(G);
        chk("sat_hold", dwell_cnt, 8'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Receive-side companion to the traffic light FSM. Consumes its 2-bit `state` bus.
- Drives registered one-hot lamp outputs, and checks the light sequence and per-phase dwell time against parameters.
- Flags protocol violations as one-cycle pulses plus a sticky summary.
- Sits between the light controller and the lamp drivers / system error logger.

Parameters:
- RED_CYC, 4, required RED dwell in clk cycles (1..2^CNT_W-1)
- GREEN_CYC, 3, required GREEN dwell in clk cycles
- YELLOW_CYC, 2, required YELLOW dwell in clk cycles
- CNT_W, 8, dwell counter width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- state  input  2  light state: 00 RED, 01 GREEN, 10 YELLOW, 11 illegal
- red_on  output  1  red lamp drive
- green_on  output  1  green lamp drive
- yellow_on  output  1  yellow lamp drive
- locked  output  1  monitor has seen a legal transition and is checking
- dwell_cnt  output  CNT_W  cycles spent in current phase, saturating
- err_illegal  output  1  pulse: code 11 sampled
- err_seq  output  1  pulse: illegal transition
- err_dwell  output  1  pulse: phase left with wrong dwell
- err_timeout  output  1  pulse: watchdog expiry (see Optional Feature)
- err_sticky  output  1  OR of all error pulses since reset
- err_code  output  2  first error cause since reset: 0 none, 1 dwell, 2 seq, 3 illegal/timeout

Behaviour:
- **Reset (rst=1 at edge):**
  - state_q=RED, dwell_cnt=0, locked=0.
  - Lamps: red_on=1, green_on=0, yellow_on=0 (fail-safe red).
  - All err_* outputs=0, err_code=0.
- **Input sampling:** `state` is registered into state_q every cycle.
- **Lamps:** one-hot decode of state_q, 1-cycle latency from `state`. When state_q=11, red_on=1 and the others are 0.
- **Transition:** a transition occurs when the new sample differs from state_q.
- **Dwell counter:**
  - Cleared to 1 on the cycle after a transition; increments otherwise.
  - Saturates at 2^CNT_W-1.
  - The counter value at the transition equals the dwell of the phase being left.
- **Monitor FSM, two states:**
  - UNLOCKED -> LOCKED on the first legal transition (R->G, G->Y, Y->R). The dwell of the first partial phase is never checked.
  - LOCKED -> UNLOCKED on a code-11 sample or on any err_seq.
  - rst forces UNLOCKED from either state.
- **Checks, only while LOCKED, evaluated at a transition:**
  - Successor not equal to the legal next state -> err_seq.
  - Legal successor but dwell of the leaving phase not equal to its *_CYC -> err_dwell.
  - Both cannot fire together; err_seq suppresses the dwell check.
- **err_illegal:** fires every cycle in which `state`=11 is sampled, in any FSM state.
- **Pulse timing:**
  - Pulses are registered and high for exactly one cycle, on the same edge as the lamp update.
  - err_illegal stays high continuously while 11 persists.
- **err_sticky / err_code:**
  - err_sticky sets on any pulse and stays set until rst.
  - err_code records the cause of the first error only.
  - Priority on a same-cycle tie: illegal/timeout=3 > seq=2 > dwell=1.
- **Return from 11:**
  - Returning from 11 to a legal code counts as a transition while UNLOCKED. No seq check is done.
  - Relock requires a further legal transition.
- **Reset mid-phase:** rst mid-phase discards the count. The next phase is treated as partial.

Optional Feature:
- Macro: TRAFFIC_LIGHT_MONITOR_TIMEOUT_EN.
- Defined:
  - While LOCKED, dwell_cnt reaching 2*max(RED_CYC,GREEN_CYC,YELLOW_CYC) without a transition pulses err_timeout once.
  - Sets err_sticky, writes err_code=3 if err_code is still 0, and sets the FSM to UNLOCKED.
  - No re-fire until the next transition.
- Not defined: err_timeout is tied 0 and no watchdog comparator is built.

Decomposition:
- Shared package traffic_light_pkg:
  - State encodings ST_RED=2'b00, ST_GREEN=2'b01, ST_YELLOW=2'b10, ST_ILLEGAL=2'b11.
  - Error code constants ERR_NONE/ERR_DWELL/ERR_SEQ/ERR_ILLEGAL.
  - next_state function: RED->GREEN->YELLOW->RED.
- The light FSM shall use the same package.
- One sub-module: tl_dwell_counter (saturating counter with clear-to-1 on transition), reusable by the light FSM itself.

Test Plan:
- Legal cycle, defaults: drive RED 4, GREEN 3, YELLOW 2 repeatedly. Required response:
  - locked=1 after first R->G.
  - No err_* pulses; err_code stays 0.
  - Lamps one-hot, 1 cycle behind `state`.
- Short GREEN once locked (GREEN held 2 cycles) -> one err_dwell pulse at G->Y, err_code=1, err_sticky=1, locked stays 1.
- Skip sequence RED->YELLOW once locked -> err_seq pulse, no err_dwell, err_code=2, locked=0. Relocks on the next legal transition.
- Drive state=11 for 3 cycles:
  - err_illegal high 3 consecutive cycles, red_on=1, green_on=0, yellow_on=0, locked=0.
  - After a prior dwell error, err_code stays 1 (first error wins).
- Assert rst for 1 cycle mid-GREEN:
  - All errors, err_code, dwell_cnt and locked clear to 0; red_on=1.
  - Following partial phase raises no err_dwell.
- With TRAFFIC_LIGHT_MONITOR_TIMEOUT_EN: hold GREEN 8 cycles once locked -> single err_timeout pulse when dwell_cnt=8, err_code=3, locked=0. Without the macro -> err_timeout stays 0.
